// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - modular exponentiation sequencer for a shared montgomery multiplier
// Left-to-right square-and-multiply; x and acc are kept in montgomery form between core ops.
module mont_exp_ctrl (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [511:0] in_x,
  input  logic [511:0] in_e,
  input  logic [9:0]   in_e_len,
  input  logic [511:0] in_m,
  input  logic [511:0] in_r,
  input  logic [511:0] in_r2,
  output logic [511:0] result,
  output logic         done,
  output logic         busy,
  output logic         mont_start,
  output logic [511:0] mont_a,
  output logic [511:0] mont_b,
  output logic [511:0] mont_m,
  input  logic [511:0] mont_result,
  input  logic         mont_done
);
  typedef enum logic [2:0] {IDLE, TOMONT, SQUARE, MULT, FROMMONT, FINISH} state_t;

  state_t       state, state_nx;
  logic         wait_ph, wait_nx;
  logic [511:0] x_q, e_q, m_q, r_q, r2_q, xm_q, acc_q;
  logic [9:0]   e_len_q, i_q;
  logic         op_state, op_done, last_bit, e_bit;

  assign op_state = (state == TOMONT) || (state == SQUARE) ||
                    (state == MULT) || (state == FROMMONT);
  assign op_done  = op_state && wait_ph && mont_done;
  assign last_bit = (i_q == 10'd0);
  assign e_bit    = e_q[i_q[8:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      wait_ph <= 1'b0;
    end else begin
      state   <= state_nx;
      wait_ph <= wait_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_ph;
    case (state)
      IDLE: begin
        wait_nx = 1'b0;
        if (start) state_nx = TOMONT;
      end
      FINISH: state_nx = IDLE;
      default: begin
        // Issue lasts exactly one cycle; a completion outside the wait phase is dropped.
        if (!wait_ph) begin
          wait_nx = 1'b1;
        end else if (mont_done) begin
          wait_nx = 1'b0;
          case (state)
            TOMONT:  state_nx = (e_len_q == 10'd0) ? FROMMONT : SQUARE;
            SQUARE:  state_nx = e_bit ? MULT : (last_bit ? FROMMONT : SQUARE);
            MULT:    state_nx = last_bit ? FROMMONT : SQUARE;
            default: state_nx = FINISH;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    mont_a = '0;
    mont_b = '0;
    case (state)
      TOMONT:   begin mont_a = x_q;   mont_b = r2_q;    end
      SQUARE:   begin mont_a = acc_q; mont_b = acc_q;   end
      MULT:     begin mont_a = acc_q; mont_b = xm_q;    end
      FROMMONT: begin mont_a = acc_q; mont_b = 512'd1;  end
      default:  ;
    endcase
  end

  assign mont_m     = m_q;
  assign mont_start = op_state && !wait_ph;
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      r2_q    <= '0;
      xm_q    <= '0;
      acc_q   <= '0;
      e_len_q <= '0;
      i_q     <= '0;
      result  <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        x_q     <= in_x;
        e_q     <= in_e;
        m_q     <= in_m;
        r_q     <= in_r;
        r2_q    <= in_r2;
        e_len_q <= (in_e_len > 10'd512) ? 10'd512 : in_e_len;
      end
    end else if (op_done) begin
      case (state)
        TOMONT: begin
          xm_q  <= mont_result;
          acc_q <= r_q;
          i_q   <= e_len_q - 10'd1;
        end
        SQUARE: begin
          acc_q <= mont_result;
          if (!e_bit && !last_bit) i_q <= i_q - 10'd1;
        end
        MULT: begin
          acc_q <= mont_result;
          if (!last_bit) i_q <= i_q - 10'd1;
        end
        default: result <= mont_result;
      endcase
    end
  end
endmodule
